// File: rtl/or1k_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : or1k_wb_arbiter2
// Two-master Wishbone arbiter (m0 = instruction bridge, m1 = data bridge)
// with registered, round-robin-on-tie grant and non-preemptive ownership.
// Optional bus watchdog enabled by defining OR1K_WB_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module or1k_wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_grant;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_wd_err;

  // --------------------------------------------------------------------------
  // State and last-grant registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_next_state == ST_GNT0) begin
        r_last_grant <= 1'b0;
      end else if (r_state == ST_IDLE && w_next_state == ST_GNT1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  // Ties go to the master that did not own the bus last; owners are never preempted.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next_state = r_last_grant ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          w_next_state = ST_GNT0;
        end else if (m1_cyc_i) begin
          w_next_state = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_gnt0 = (r_state == ST_GNT0) && !rst;
  assign w_gnt1 = (r_state == ST_GNT1) && !rst;

  // --------------------------------------------------------------------------
  // Slave-side request mux
  // --------------------------------------------------------------------------
  always_comb begin
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'd0;
    s_bte_o = 2'd0;
    if (w_gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      // stb is masked by cyc so a released owner leaves the bus idle this cycle
      s_stb_o = m0_cyc_i & m0_stb_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (w_gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_cyc_i & m1_stb_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  // --------------------------------------------------------------------------
  // Master-side responses
  // --------------------------------------------------------------------------
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = w_gnt0 & s_ack_i;
  assign m0_err_o = w_gnt0 & (s_err_i | w_wd_err);
  assign m0_rty_o = w_gnt0 & s_rty_i;
  assign m1_ack_o = w_gnt1 & s_ack_i;
  assign m1_err_o = w_gnt1 & (s_err_i | w_wd_err);
  assign m1_rty_o = w_gnt1 & s_rty_i;

  // --------------------------------------------------------------------------
  // Bus watchdog
  // --------------------------------------------------------------------------
`ifdef OR1K_WB_ARB_WATCHDOG_EN
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_wd_cnt;
  logic        w_term;

  assign w_term   = s_ack_i | s_err_i | s_rty_i;
  assign w_wd_err = (r_state != ST_IDLE) && (r_wd_cnt == c_TIMEOUT);

  // Counts stalled strobe cycles; the timeout error itself restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == ST_IDLE || w_term || w_wd_err) begin
      r_wd_cnt <= 16'd0;
    end else if (s_stb_o) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end
`else
  // Timeout limit has no function without the watchdog.
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_wd_err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_or1k_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_or1k_wb_arbiter2
// Scoreboard bench for or1k_wb_arbiter2: grants and terminations are queued
// as expected events and matched by an independent negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or1k_wb_arbiter2;

  localparam int TMO = 4;

  localparam logic [1:0] K_GNT = 2'd1;
  localparam logic [1:0] K_TRM = 2'd2;
  // termination flags: {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}
  localparam logic [5:0] F_M0ACK = 6'b100000;
  localparam logic [5:0] F_M0ERR = 6'b010000;
  localparam logic [5:0] F_M1ACK = 6'b000100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;

  or1k_wb_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [5:0]  flags;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] cyc;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [5:0] gflags(input logic we);
    return {we, 1'b0, 4'hF};
  endfunction

  task automatic push(input string name, input logic [1:0] kind, input logic [5:0] flags,
                      input logic [31:0] adr, input logic [31:0] dat, input int cyc);
    ev_t e;
    e = '{kind: kind, flags: flags, adr: adr, dat: dat, cyc: 32'(cyc)};
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic compare(input ev_t got);
    ev_t   e;
    string nm;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d flags=%b adr=%h dat=%h cycle=%0d, expected no event",
               got.kind, got.flags, got.adr, got.dat, got.cyc);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got kind=%0d flags=%b adr=%h dat=%h cycle=%0d, expected kind=%0d flags=%b adr=%h dat=%h cycle=%0d",
                 nm, got.kind, got.flags, got.adr, got.dat, got.cyc,
                 e.kind, e.flags, e.adr, e.dat, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a grant is a rising s_cyc_o; a termination is any ack/err/rty to a master.
  logic prev_cyc = 1'b0;
  always @(negedge clk) begin
    ev_t        got;
    logic [5:0] tf;
    tf = {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o};
    if (s_cyc_o && !prev_cyc) begin
      got = '{kind: K_GNT, flags: {s_we_o, 1'b0, s_sel_o}, adr: s_adr_o, dat: s_dat_o, cyc: 32'(cyc_n)};
      compare(got);
    end
    if (tf != 6'd0) begin
      got = '{kind: K_TRM, flags: tf, adr: s_adr_o,
              dat: (m1_ack_o | m1_err_o | m1_rty_o) ? m1_dat_o : m0_dat_o, cyc: 32'(cyc_n)};
      compare(got);
    end
    prev_cyc = s_cyc_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic c, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] cti);
    m_cyc[i] = c;
    m_stb[i] = c;
    m_we[i]  = we;
    m_adr[i] = a;
    m_dat[i] = d;
    m_sel[i] = 4'hF;
    m_cti[i] = cti;
    m_bte[i] = 2'b00;
  endtask

  initial begin
    int t;
    int errs;
    rst = 1'b1;
    s_dat_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack_i = 1'b1; s_err_i = 1'b1;

    // reset holds the slave port and every termination low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_s_adr", s_adr_o, 32'd0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
    chk("rst_m0_err", 32'(m0_err_o), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack_o), 32'd0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack_i = 1'b0; s_err_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'(s_cyc_o), 32'd0);

    // tie right after reset: m1 first, one idle cycle, then m0
    t = cyc_n;
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 3'b000);
    set_m(1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222_2222, 3'b000);
    push("tie_gnt_m1", K_GNT, gflags(1'b1), 32'h0000_0200, 32'h2222_2222, t + 1);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h5555_0001;
    push("tie_ack_m1", K_TRM, F_M1ACK, 32'h0000_0200, 32'h5555_0001, t + 1);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    push("tie_gnt_m0", K_GNT, gflags(1'b0), 32'h0000_0100, 32'h0000_0000, t + 4);
    tick();
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h5555_0002;
    push("tie_ack_m0", K_TRM, F_M0ACK, 32'h0000_0100, 32'h5555_0002, t + 4);
    tick();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) tick();

    // single write from m1
    t = cyc_n;
    set_m(1, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b000);
    push("single_gnt", K_GNT, gflags(1'b1), 32'h0000_1000, 32'hDEAD_BEEF, t + 1);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
    push("single_ack", K_TRM, F_M1ACK, 32'h0000_1000, 32'hCAFE_0001, t + 1);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) tick();

    // m0 8-beat incrementing burst; m1 waits until two cycles after release
    t = cyc_n;
    set_m(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b010);
    push("burst_gnt_m0", K_GNT, gflags(1'b0), 32'h0000_3000, 32'h0, t + 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) set_m(1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0044, 3'b000);
      set_m(0, 1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'(i), (i == 7) ? 3'b111 : 3'b010);
      s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + 32'(i);
      push($sformatf("burst_ack_%0d", i), K_TRM, F_M0ACK,
           32'h0000_3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), t + 1 + i);
    end
    tick();
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    push("burst_gnt_m1", K_GNT, gflags(1'b0), 32'h0000_4000, 32'h0000_0044, t + 11);
    tick();
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hB000_0001;
    push("burst_ack_m1", K_TRM, F_M1ACK, 32'h0000_4000, 32'hB000_0001, t + 11);
    tick();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) tick();

    // asynchronous reset in the middle of an m1 grant
    set_m(1, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_0055, 3'b000);
    tick();
    chk("arst_pre_grant", 32'(s_cyc_o), 32'd1);
    #1;
    rst = 1'b1;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    chk("arst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("arst_s_stb", 32'(s_stb_o), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("arst_idle", 32'(s_cyc_o), 32'd0);
    tick();

    // alternation starting from the reset last_grant: m1, m0, m1, m0
    t = cyc_n;
    set_m(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_0060, 3'b000);
    set_m(1, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_0070, 3'b000);
    for (int k = 0; k < 4; k++) begin
      automatic int          g   = t + 1 + 3 * k;
      automatic int          mi  = (k % 2 == 0) ? 1 : 0;
      automatic logic [31:0] adr = (mi == 1) ? 32'h0000_7000 : 32'h0000_6000;
      automatic logic [31:0] dat = (mi == 1) ? 32'h0000_0070 : 32'h0000_0060;
      push($sformatf("alt_gnt_%0d", k), K_GNT, gflags(mi == 1), adr, dat, g);
      tick();
      s_ack_i = 1'b1; s_dat_i = 32'hC000_0000 + 32'(k);
      push($sformatf("alt_ack_%0d", k), K_TRM, (mi == 1) ? F_M1ACK : F_M0ACK,
           adr, 32'hC000_0000 + 32'(k), g);
      tick();
      s_ack_i = 1'b0;
      set_m(mi, 1'b0, mi == 1, adr, dat, 3'b000);
      tick();
      if (k < 3) set_m(mi, 1'b1, mi == 1, adr, dat, 3'b000);
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (2) tick();

    // stalled slave
    t = cyc_n;
    s_dat_i = 32'hEEEE_0000;
    set_m(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_0080, 3'b000);
    push("wd_gnt_m0", K_GNT, gflags(1'b0), 32'h0000_8000, 32'h0000_0080, t + 1);
`ifdef OR1K_WB_ARB_WATCHDOG_EN
    push("wd_err_m0", K_TRM, F_M0ERR, 32'h0000_8000, 32'hEEEE_0000, t + 1 + TMO);
    repeat (1 + TMO) tick();
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) tick();
`else
    errs = 0;
    repeat (1000) begin
      tick();
      if (m0_err_o || m1_err_o) errs++;
    end
    chk("no_watchdog_err", 32'(errs), 32'd0);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) tick();
`endif

    while (exp_q.size() > 0) begin
      ev_t   e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event, expected kind=%0d flags=%b adr=%h cycle=%0d",
               nm, e.kind, e.flags, e.adr, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/or1k_wb_arbiter2.md
OR1K_WB_ARBITER2 -- requirements
Module: or1k_wb_arbiter2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, valid range 1..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-004 SHALL have ports m0_adr_i/m1_adr_i, input, 32: master address. m0 is the instruction bridge; m1 is the data bridge.
REQ-005 SHALL have ports m0_dat_i/m1_dat_i, input, 32: master write data.
REQ-006 SHALL have ports m0_sel_i/m1_sel_i, input, 4: master byte selects.
REQ-007 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i and m1_we_i, m1_cyc_i, m1_stb_i, input, 1 each: master Wishbone controls.
REQ-008 SHALL have ports m0_cti_i/m1_cti_i, input, 3 and m0_bte_i/m1_bte_i, input, 2: master burst tags.
REQ-009 SHALL have ports m0_dat_o/m1_dat_o, output, 32: read data to each master.
REQ-010 SHALL have ports m0_ack_o, m0_err_o, m0_rty_o and m1_ack_o, m1_err_o, m1_rty_o, output, 1 each: per-master terminations.
REQ-011 SHALL have ports s_adr_o (32), s_dat_o (32), s_sel_o (4), s_we_o, s_cyc_o, s_stb_o (1 each), s_cti_o (3), s_bte_o (2), output: shared slave port.
REQ-012 SHALL have ports s_dat_i (32) and s_ack_i, s_err_i, s_rty_i (1 each), input: slave responses.

Function
REQ-013 SHALL implement states IDLE, GNT0 and GNT1, plus a 1-bit last_grant register.
REQ-014 IDLE, at least one cycN high: SHALL move to GNT0 or GNT1 on the next edge. Both high: grant the master not equal to last_grant. One high: grant that master.
REQ-015 On entering GNTn, SHALL set last_grant to n.
REQ-016 SHALL make the grant registered: a cyc first seen in IDLE at cycle N reaches s_cyc_o at cycle N+1.
REQ-017 In GNTn, SHALL drive all s_* outputs from master n; cyc and stb pass through unchanged.
REQ-018 In IDLE, SHALL drive every s_* output to 0.
REQ-019 In GNTn, SHALL hold the grant while mN_cyc_i is high, including bursts (cti 001/010) and cycles with stb low.
REQ-020 SHALL never preempt the granted master.
REQ-021 GNTn with mN_cyc_i low: SHALL combinationally force s_cyc_o and s_stb_o to 0 and return to IDLE on the next edge. This gives one idle bus cycle between grants.
REQ-022 SHALL drive s_dat_i onto m0_dat_o and m1_dat_o unconditionally.
REQ-023 SHALL pass s_ack_i, s_err_i and s_rty_i only to the granted master; the other master's ack, err and rty SHALL be 0.
REQ-024 A master that drops cyc mid-burst SHALL release the bus per REQ-021. No termination is synthesised.

Reset
REQ-025 On rst assertion, SHALL immediately (asynchronously) set state to IDLE, last_grant to 0 and the watchdog count to 0.
REQ-026 While rst is high, all s_* outputs and all mN_ack/err/rty outputs SHALL be 0.
REQ-027 Reset mid-transfer SHALL abandon the transfer; nothing is replayed.
REQ-028 After reset, the first simultaneous request SHALL be granted to m1.

Configuration
REQ-029 SHALL use macro OR1K_WB_ARB_WATCHDOG_EN.
REQ-030 With OR1K_WB_ARB_WATCHDOG_EN defined, the 16-bit counter SHALL increment each cycle with s_stb_o high and no ack, err or rty.
REQ-031 The counter SHALL clear on any termination and in IDLE.
REQ-032 When the count equals TIMEOUT_CYCLES, SHALL assert err to the granted master for exactly one cycle and clear the counter. The s_* outputs SHALL be unaffected.
REQ-033 Without OR1K_WB_ARB_WATCHDOG_EN, SHALL contain no counter logic, wait on the slave indefinitely, and take err only from s_err_i.

Verification
REQ-034 Single request: m1 cyc/stb with adr 0x0000_1000, we=1, dat 0xDEADBEEF at cycle 0 -> s_cyc_o=1 at cycle 1 with the same adr/dat; s_ack_i -> m1_ack_o=1, m0_ack_o=0.
REQ-035 Tie after reset: m0 and m1 assert cyc in the same cycle -> m1 granted. m1 completes and drops cyc -> one IDLE cycle, then m0 granted.
REQ-036 Burst hold: m0 8-beat burst (cti 010, final 111) while m1 requests -> all 8 acks go to m0 only; m1 is granted 2 cycles after m0 drops cyc.
REQ-037 Async reset during m1 grant: rst pulses mid-cycle -> s_cyc_o and s_stb_o are 0 the same cycle; state is IDLE; last_grant=0.
REQ-038 Watchdog (macro defined, TIMEOUT_CYCLES=4): slave never acks -> granted m0_err_o=1 exactly 4 cycles after stb, for one cycle. Macro undefined -> no err after 1000 cycles.
REQ-039 Alternation: m0 and m1 each hold cyc high continuously, releasing after every single transfer -> grants strictly alternate m1, m0, m1, m0.
